spi_tx: RTL and testbench
=========================

// Module: spi_tx
// PURPOSE
//   SPI transmitter (bus master) producing SS_n/SCLK/MOSI frames that the SPI
//   trigger receiver decodes. Sends one 16-bit or 8-bit word, MSB first, with
//   selectable sampling edge. Used as an on-chip stimulus/loopback source for
//   the SPI trigger path; shares the capture clock domain.
// PARAMETERS
//   CLK_DIV  4  clk cycles per SCLK half-period; must be >= 4 so 3-flop receivers resolve every edge
// PORTS
//   clk     in   1   system clock
//   rst     in   1   synchronous reset, active high
//   start   in   1   request a frame; accepted only in IDLE
//   data    in   16  word to send; latched on accept
//   len8    in   1   1 = send data[7:0] only (8 bits); 0 = send all 16 bits; latched on accept
//   edg     in   1   edge on which the receiver samples: 1 = SCLK rise, 0 = SCLK fall; latched on accept
//   SS_n    out  1   active-low slave select
//   SCLK    out  1   serial clock, idles high
//   MOSI    out  1   serial data, MSB first
//   busy    out  1   high from the cycle after accept through the end of GAP
//   done    out  1   one-cycle pulse, in the same cycle SS_n returns high
// BEHAVIOUR
//   - Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
//   - All outputs are registered, so they are glitch-free.
//   - Reset values: SS_n=1, SCLK=1, MOSI=0, busy=0, done=0; state=IDLE; counters=0.
//   - N = 8 if len8 else 16. H = CLK_DIV.
//   - Shift register sh[15:0] is loaded on accept with data, or {data[7:0],8'h00} if len8.
//     MOSI = sh[15] while SS_n is low; MOSI = 0 while SS_n is high.
//   - FSM: IDLE -> FRONT -> SHIFT -> BACK -> GAP -> IDLE.
//     IDLE:  if start=1, latch inputs; next cycle SS_n=0, busy=1, enter FRONT. MOSI = first bit.
//     FRONT: H cycles; SCLK=1.
//     SHIFT: 2N half-periods of H cycles each. SCLK=0 in even halves, 1 in odd halves,
//            so every bit is one falling edge followed by one rising edge.
//            edg=1: sh shifts left on every SCLK fall except the first
//                   (bit k is stable across rise k).
//            edg=0: sh shifts left on every SCLK rise except the last
//                   (bit k is stable across fall k).
//     BACK:  H cycles; SCLK=1, SS_n=0.
//     GAP:   SS_n=1, done=1 in the first GAP cycle only; lasts H cycles, busy stays 1;
//            then enter IDLE with busy=0.
//   - SS_n is low for exactly H*(2N+2) cycles. The minimum SS_n-high time between frames is H cycles.
//   - start while busy is ignored (no queueing). start held high gives back-to-back frames.
//   - data, len8 and edg may change after accept without affecting the frame in flight.
//   - Counters: half-period counter $clog2(CLK_DIV) bits; half-edge counter 5 bits (max 32).
//   - rst mid-frame: outputs take reset values on the next edge, and no done pulse is issued.
//     A receiver sees a truncated frame ending in an SS_n rise; this is accepted behaviour.
// TESTING
//   1. H=4, edg=1, len8=0, data=16'hA5C3, one-cycle start:
//      -> SS_n low 136 cycles; 16 falls + 16 rises; bits at rises = A5C3; one done;
//      -> SPI_RX with match=A5C3, mask=0 pulses SPItrig.
//   2. edg=0, len8=1, data=16'hFF3C:
//      -> SS_n low 72 cycles; 8 falls; bits at falls = 8'h3C;
//      -> SPI_RX (len8=1, edg=0, match=003C) triggers.
//   3. start pulsed again at cycle 20 with data=16'h1234:
//      -> ignored; exactly one frame (A5C3); busy stays high until GAP ends.
//   4. data changes to 16'h0000 one cycle after accept:
//      -> transmitted bits are still A5C3.
//   5. rst asserted after the 5th SCLK fall:
//      -> next cycle SS_n=1, SCLK=1, MOSI=0, busy=0, no done; a following start sends a full correct frame.
//   6. start held high for 3 frames, data=16'h8001:
//      -> SS_n high exactly 4 cycles between frames; three done pulses; each frame = 8001.

Source files
------------

// File: rtl/spi_tx.sv
// SPI master sending one 8/16-bit word MSB first on SS_n/SCLK/MOSI, sampling edge selectable.
// All outputs registered; start is accepted only when idle, so requests while busy are dropped.
module spi_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data,
  input  logic        len8,
  input  logic        edg,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        busy,
  output logic        done
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] H_LAST   = HW'(CLK_DIV - 1);
  localparam logic [HW-1:0] GAP_LAST = HW'(CLK_DIV - 2);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FRONT = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] BACK  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]    state;
  logic [HW-1:0] hcnt;
  logic [4:0]    ecnt;
  logic [15:0]   sh;
  logic          n8;
  logic          edg_r;
  logic [4:0]    last_half;
  logic [4:0]    last_rise;
  logic          do_shift;

  // sh is cleared whenever SS_n goes high, so its MSB is the MOSI register.
  assign MOSI = sh[15];

  assign last_half = n8 ? 5'd15 : 5'd31;
  assign last_rise = n8 ? 5'd14 : 5'd30;

  // ecnt odd: next half starts with a fall; ecnt even: next half starts with a rise.
  always_comb begin
    do_shift = 1'b0;
    if (ecnt[0])
      do_shift = edg_r;
    else
      do_shift = !edg_r && (ecnt != last_rise);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= '0;
      ecnt  <= '0;
      sh    <= '0;
      n8    <= 1'b0;
      edg_r <= 1'b0;
      SS_n  <= 1'b1;
      SCLK  <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh    <= len8 ? {data[7:0], 8'h00} : data;
            n8    <= len8;
            edg_r <= edg;
            SS_n  <= 1'b0;
            busy  <= 1'b1;
            hcnt  <= '0;
            state <= FRONT;
          end
        end
        FRONT: begin
          if (hcnt == H_LAST) begin
            hcnt  <= '0;
            ecnt  <= '0;
            SCLK  <= 1'b0;
            state <= SHIFT;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        SHIFT: begin
          if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (ecnt == last_half) begin
              state <= BACK;
            end else begin
              ecnt <= ecnt + 5'd1;
              SCLK <= ~SCLK;
              if (do_shift)
                sh <= {sh[14:0], 1'b0};
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        BACK: begin
          if (hcnt == H_LAST) begin
            hcnt  <= '0;
            SS_n  <= 1'b1;
            sh    <= '0;
            done  <= 1'b1;
            state <= GAP;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        GAP: begin
          // The IDLE accept cycle completes the H-cycle SS_n-high spacing.
          if (hcnt == GAP_LAST) begin
            hcnt  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx.sv
// Directed bench for spi_tx: table of single frames plus ignore/latch/reset/back-to-back sequences.
module tb_spi_tx;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data;
  logic        len8;
  logic        edg;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        busy;
  logic        done;

  spi_tx #(.CLK_DIV(H)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (data),
    .len8 (len8),
    .edg  (edg),
    .SS_n (SS_n),
    .SCLK (SCLK),
    .MOSI (MOSI),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Line monitor, sampled on the falling clk edge.
  logic        mon_edg = 1'b1;
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b1;
  logic [15:0] rx = 16'h0;
  int low_cnt = 0, falls = 0, rises = 0, busy_cnt = 0, done_cnt = 0, hi_run = 0;
  int          hi_q[$];
  logic [15:0] frame_q[$];

  always @(negedge clk) begin
    if (prev_ss && !SS_n) begin
      hi_q.push_back(hi_run);
      rx = 16'h0;
    end
    if (!SS_n) begin
      low_cnt++;
      hi_run = 0;
      if (SCLK != prev_sclk) begin
        if (!SCLK) begin
          falls++;
          if (!mon_edg) rx = {rx[14:0], MOSI};
        end else begin
          rises++;
          if (mon_edg) rx = {rx[14:0], MOSI};
        end
      end
    end else begin
      hi_run++;
    end
    if (!prev_ss && SS_n) frame_q.push_back(rx);
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    prev_ss   = SS_n;
    prev_sclk = SCLK;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic        l8;
    logic        e;
    logic [15:0] bits;
    int          nbits;
    int          low;
    int          busy_cyc;
  } vec_t;

  vec_t vecs[4];

  int b_low, b_falls, b_rises, b_busy, b_done, b_frames;

  task automatic snap();
    b_low = low_cnt; b_falls = falls; b_rises = rises;
    b_busy = busy_cnt; b_done = done_cnt; b_frames = frame_q.size();
  endtask

  // One-cycle start; optional mid-frame re-request and post-accept input change.
  task automatic run_frame(input logic [15:0] d, input logic l8, input logic e,
                           input int restart_at, input int change_at);
    bit fin;
    mon_edg = e;
    snap();
    @(negedge clk);
    start = 1'b1; data = d; len8 = l8; edg = e;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    fin = 1'b0;
    for (int c = 1; c < 600; c++) begin
      if (c == change_at) begin
        data = 16'h0000; len8 = ~l8; edg = ~e;
      end
      if (c == restart_at) begin
        start = 1'b1; data = 16'h1234;
      end
      if (c == restart_at + 1) start = 1'b0;
      @(negedge clk);
      if (!busy) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) chk("frame_timeout", 0, 1);
    repeat (12) @(negedge clk);
    @(posedge clk);
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    chk({tag, "_ss_low"}, low_cnt - b_low, v.low);
    chk({tag, "_falls"}, falls - b_falls, v.nbits);
    chk({tag, "_rises"}, rises - b_rises, v.nbits);
    chk({tag, "_done"}, done_cnt - b_done, 1);
    chk({tag, "_busy_cyc"}, busy_cnt - b_busy, v.busy_cyc);
    chk({tag, "_frames"}, frame_q.size() - b_frames, 1);
    if (frame_q.size() > b_frames) chk({tag, "_bits"}, int'(frame_q[b_frames]), int'(v.bits));
  endtask

  initial begin
    bit ok;
    vecs[0] = '{16'hA5C3, 1'b0, 1'b1, 16'hA5C3, 16, 136, 139};
    vecs[1] = '{16'hFF3C, 1'b1, 1'b0, 16'h003C, 8, 72, 75};
    vecs[2] = '{16'h8001, 1'b0, 1'b0, 16'h8001, 16, 136, 139};
    vecs[3] = '{16'h1296, 1'b1, 1'b1, 16'h0096, 8, 72, 75};

    rst = 1'b1; start = 1'b0; data = 16'h0; len8 = 1'b0; edg = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss_n", int'(SS_n), 1);
    chk("rst_sclk", int'(SCLK), 1);
    chk("rst_mosi", int'(MOSI), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].d, vecs[i].l8, vecs[i].e, -10, -10);
      check_frame($sformatf("vec%0d", i), vecs[i]);
    end

    // start while busy is dropped
    run_frame(16'hA5C3, 1'b0, 1'b1, 20, -10);
    check_frame("ignore", vecs[0]);

    // inputs changing after accept do not affect the frame
    run_frame(16'hA5C3, 1'b0, 1'b1, -10, 1);
    check_frame("latch", vecs[0]);

    // reset after the 5th SCLK fall
    mon_edg = 1'b1;
    snap();
    @(negedge clk);
    start = 1'b1; data = 16'hA5C3; len8 = 1'b0; edg = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (falls - b_falls >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst5_reach_fall5", int'(ok), 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst5_ss_n", int'(SS_n), 1);
    chk("rst5_sclk", int'(SCLK), 1);
    chk("rst5_mosi", int'(MOSI), 0);
    chk("rst5_busy", int'(busy), 0);
    repeat (10) @(posedge clk);
    chk("rst5_no_done", done_cnt - b_done, 0);
    run_frame(16'hA5C3, 1'b0, 1'b1, -10, -10);
    check_frame("after_rst", vecs[0]);

    // start held high: three back-to-back frames
    mon_edg = 1'b1;
    snap();
    @(negedge clk);
    start = 1'b1; data = 16'h8001; len8 = 1'b0; edg = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      if (done_cnt - b_done >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b2b_three_done", int'(ok), 1);
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b2b_idle", int'(ok), 1);
    repeat (12) @(negedge clk);
    @(posedge clk);
    chk("b2b_frames", frame_q.size() - b_frames, 3);
    chk("b2b_done_cnt", done_cnt - b_done, 3);
    chk("b2b_ss_low", low_cnt - b_low, 3 * 136);
    for (int k = 0; k < 3; k++)
      if (b_frames + k < frame_q.size())
        chk($sformatf("b2b_bits%0d", k), int'(frame_q[b_frames + k]), 16'h8001);
    for (int k = 1; k < 3; k++)
      if (b_frames + k < hi_q.size())
        chk($sformatf("b2b_gap%0d", k), hi_q[b_frames + k], H);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
